step_sequencer: RTL and testbench

//   Multi-cycle control FSM for the single-issue core datapath: owns the PC and

---
 rtl/step_sequencer_if.sv | 23 ++
 rtl/step_sequencer.sv | 120 ++++++++++++
 tb/tb_step_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/step_sequencer_if.sv
// Control/status bundle between the step sequencer and the core datapath:
// user inputs and the current opcode in, PC and per-step enable pulses out.
interface step_sequencer_if;
  logic        button;
  logic        run_mode;
  logic [6:0]  instr_opcode;
  logic [31:0] pc;
  logic        ir_load;
  logic        reg_we;
  logic        step_done;
  logic        illegal;
  logic [1:0]  fsm_state;

  modport slave (
    input  button, run_mode, instr_opcode,
    output pc, ir_load, reg_we, step_done, illegal, fsm_state
  );

  modport master (
    output button, run_mode, instr_opcode,
    input  pc, ir_load, reg_we, step_done, illegal, fsm_state
  );
endinterface

// File: rtl/step_sequencer.sv
// Multi-cycle FETCH/EXEC/WB sequencer owning the PC. Steps are started by a
// free-running tick divider (run mode) or a debounced push button (step mode).
module step_sequencer #(
  parameter int unsigned MEM_SIZE = 64,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DEBOUNCE = 1000000,
  parameter logic [6:0]  OPC_I    = 7'b0010011,
  parameter logic [6:0]  OPC_R    = 7'b0110011
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  step_sequencer_if.slave  bus
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [31:0]   PC_LIMIT  = 32'(MEM_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  state_e          state_q;
  logic [31:0]     pc_q, pc_d;
  logic            legal_q;
  logic            illegal_q;

  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;

  logic            btn_meta_q, btn_sync_q;
  logic            db_level_q, db_level_d;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic            press;
  logic            step_req;

  // NOTE: every signal driven in always_comb gets a default on entry, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // The debounced level only follows the synchronised button after it has
  // disagreed for DEBOUNCE consecutive cycles; any agreement restarts the count.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    press      = 1'b0;
    if (btn_sync_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = btn_sync_q;
        press      = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    step_req = bus.run_mode ? tick : press;
    pc_d     = pc_q + 32'd4;
    if (pc_d >= PC_LIMIT) pc_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order; reset is synchronous.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      legal_q    <= 1'b0;
      illegal_q  <= 1'b0;
      tick_cnt_q <= '0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      btn_meta_q <= bus.button;
      btn_sync_q <= btn_meta_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;

      case (state_q)
        ST_IDLE: begin
          if (step_req) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          legal_q <= (bus.instr_opcode == OPC_I) || (bus.instr_opcode == OPC_R);
          state_q <= ST_WB;
        end
        ST_WB: begin
          // Illegal instructions still retire and advance the PC.
          if (!legal_q) illegal_q <= 1'b1;
          pc_q    <= pc_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ir_load   = (state_q == ST_FETCH);
  assign bus.reg_we    = (state_q == ST_WB) && legal_q;
  assign bus.step_done = (state_q == ST_WB);
  assign bus.illegal   = illegal_q;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with small divider/debounce/memory sizes
// so every step boundary can be hand-timed.
module tb_step_sequencer;

  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_LD = 7'b0000011;

  logic clk = 1'b0;
  logic sys_rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_ir = 0, n_we = 0, n_sd = 0;
  int   b_ir, b_we, b_sd;
  int   last_sd_cyc;

  step_sequencer_if u_if ();

  step_sequencer #(
    .MEM_SIZE (16),
    .TICK_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .bus     (u_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (u_if.ir_load   === 1'b1) n_ir <= n_ir + 1;
    if (u_if.reg_we    === 1'b1) n_we <= n_we + 1;
    if (u_if.step_done === 1'b1) n_sd <= n_sd + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_ir = n_ir;
    b_we = n_we;
    b_sd = n_sd;
  endtask

  // Returns at the negedge inside WB, or after the budget has expired.
  task automatic wait_step_done(input string tag, input int budget);
    int n = 0;
    while (u_if.step_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b0;
    repeat (n) @(negedge clk);
    sys_rst = 1'b1;
  endtask

  initial begin
    int cur_pc;
    sys_rst           = 1'b0;
    u_if.button       = 1'b1;
    u_if.run_mode     = 1'b0;
    u_if.instr_opcode = OPC_I;

    // Reset with button held pressed
    repeat (3) @(negedge clk);
    check("rst_pc",      u_if.pc, 32'd0);
    check("rst_state",   32'(u_if.fsm_state), 32'd0);
    check("rst_ir_load", 32'(u_if.ir_load), 32'd0);
    check("rst_reg_we",  32'(u_if.reg_we), 32'd0);
    check("rst_done",    32'(u_if.step_done), 32'd0);
    check("rst_illegal", 32'(u_if.illegal), 32'd0);

    // Run mode: five steps, one every 4 cycles, PC wraps at 16
    u_if.button   = 1'b0;
    u_if.run_mode = 1'b1;
    sys_rst       = 1'b1;
    snap();
    cur_pc      = 0;
    last_sd_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_step_done("run_wait", 12);
      check("run_wb_pc",     u_if.pc, 32'(cur_pc));
      check("run_wb_reg_we", 32'(u_if.reg_we), 32'd1);
      if (k > 0) check("run_period", 32'(cyc - last_sd_cyc), 32'd4);
      last_sd_cyc = cyc;
      cur_pc = (cur_pc + 4) % 16;
      if (k == 4) u_if.run_mode = 1'b0;
      @(negedge clk);
      check("run_next_pc", u_if.pc, 32'(cur_pc));
      check("run_idle",    32'(u_if.fsm_state), 32'd0);
    end
    repeat (10) @(negedge clk);
    check("run_ir_cnt",  32'(n_ir - b_ir), 32'd5);
    check("run_we_cnt",  32'(n_we - b_we), 32'd5);
    check("run_sd_cnt",  32'(n_sd - b_sd), 32'd5);
    check("run_illegal", 32'(u_if.illegal), 32'd0);
    check("run_pc_held", u_if.pc, 32'd4);

    // Step mode: short press ignored, long press gives exactly one step
    u_if.run_mode = 1'b0;
    do_reset(2);
    snap();
    repeat (2) @(negedge clk);
    u_if.button = 1'b1;
    repeat (2) @(negedge clk);
    u_if.button = 1'b0;
    repeat (10) @(negedge clk);
    check("short_sd_cnt", 32'(n_sd - b_sd), 32'd0);
    check("short_pc",     u_if.pc, 32'd0);
    u_if.button = 1'b1;
    repeat (6) @(negedge clk);
    u_if.button = 1'b0;
    wait_step_done("press_wait", 10);
    check("press_wb_pc", u_if.pc, 32'd0);
    @(negedge clk);
    check("press_pc", u_if.pc, 32'd4);
    repeat (10) @(negedge clk);
    check("press_sd_cnt", 32'(n_sd - b_sd), 32'd1);
    check("press_ir_cnt", 32'(n_ir - b_ir), 32'd1);

    // Held press with a one-cycle dropout: still only one step
    u_if.button = 1'b1;
    repeat (8) @(negedge clk);
    u_if.button = 1'b0;
    @(negedge clk);
    u_if.button = 1'b1;
    repeat (8) @(negedge clk);
    u_if.button = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_sd_cnt", 32'(n_sd - b_sd), 32'd2);
    check("glitch_pc",     u_if.pc, 32'd8);

    // 1-0-1 bounce from released: no step
    u_if.button = 1'b1;
    @(negedge clk);
    u_if.button = 1'b0;
    @(negedge clk);
    u_if.button = 1'b1;
    @(negedge clk);
    u_if.button = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_sd_cnt", 32'(n_sd - b_sd), 32'd2);
    check("bounce_pc",     u_if.pc, 32'd8);
    check("bounce_state",  32'(u_if.fsm_state), 32'd0);

    // Illegal opcode retires without a write, flag is sticky
    u_if.run_mode     = 1'b1;
    u_if.instr_opcode = OPC_LD;
    do_reset(2);
    snap();
    wait_step_done("ill_wait", 12);
    check("ill_reg_we",   32'(u_if.reg_we), 32'd0);
    check("ill_flag_wb",  32'(u_if.illegal), 32'd0);
    u_if.instr_opcode = OPC_R;
    @(negedge clk);
    check("ill_flag",     32'(u_if.illegal), 32'd1);
    check("ill_pc",       u_if.pc, 32'd4);
    wait_step_done("opr_wait", 12);
    check("opr_reg_we",   32'(u_if.reg_we), 32'd1);
    u_if.run_mode = 1'b0;
    @(negedge clk);
    check("opr_flag",     32'(u_if.illegal), 32'd1);
    check("opr_pc",       u_if.pc, 32'd8);
    check("ill_we_cnt",   32'(n_we - b_we), 32'd1);
    check("ill_sd_cnt",   32'(n_sd - b_sd), 32'd2);

    // Reset during EXEC aborts the step
    u_if.run_mode     = 1'b1;
    u_if.instr_opcode = OPC_I;
    do_reset(2);
    snap();
    repeat (5) @(negedge clk);
    check("abort_in_exec", 32'(u_if.fsm_state), 32'd2);
    sys_rst = 1'b0;
    @(negedge clk);
    check("abort_state",  32'(u_if.fsm_state), 32'd0);
    check("abort_pc",     u_if.pc, 32'd0);
    check("abort_reg_we", 32'(u_if.reg_we), 32'd0);
    u_if.run_mode = 1'b0;
    sys_rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_we_cnt", 32'(n_we - b_we), 32'd0);
    check("abort_pc_end", u_if.pc, 32'd0);

    // Tick-started step; debounced press lands during FETCH and is dropped
    u_if.run_mode = 1'b1;
    u_if.button   = 1'b1;
    do_reset(2);
    snap();
    repeat (4) @(negedge clk);
    check("drop_in_fetch", 32'(u_if.fsm_state), 32'd1);
    u_if.run_mode = 1'b0;
    wait_step_done("drop_wait", 10);
    @(negedge clk);
    check("drop_pc", u_if.pc, 32'd4);
    repeat (15) @(negedge clk);
    check("drop_pc_end", u_if.pc, 32'd4);
    check("drop_sd_cnt", 32'(n_sd - b_sd), 32'd1);
    check("drop_state",  32'(u_if.fsm_state), 32'd0);
    u_if.button = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
